// File: rtl/pipe_buffer.sv
// Valid/ready pipeline stage register with flush and optional two-entry skid.
// Define PIPE_BUFFER_SKID_EN to build the skid variant (registered in_ready, count up to 2).
module pipe_buffer #(
  parameter int unsigned     W   = 16,
  parameter logic [W-1:0]    RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  // State encoding doubles as the held-entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef PIPE_BUFFER_SKID_EN
  localparam logic [1:0] ST_TWO   = 2'd2;
`endif

  logic [1:0]   state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic         accept, consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_q;
  assign count     = state_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

`ifdef PIPE_BUFFER_SKID_EN
  logic [W-1:0] s_q, s_d;
  logic         in_ready_q;

  // in_ready comes straight from a flop so upstream sees no path from out_ready.
  assign in_ready = in_ready_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          m_d     = in_data;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          m_d = in_data;
        end else if (accept) begin
          state_d = ST_TWO;
          s_d     = in_data;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      m_q        <= RST;
      s_q        <= RST;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

`else
  // Without the skid a held entry can only be replaced when it leaves this cycle.
  assign in_ready = (state_q == ST_EMPTY) | out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          m_d     = in_data;
        end
      end
      ST_ONE: begin
        if (accept) begin
          m_d = in_data;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= RST;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: queue-based reference model checked every cycle plus directed literal checks.
// Works for both builds; PIPE_BUFFER_SKID_EN selects the skid expectations.
module tb_pipe_buffer;
  localparam int W = 16;
`ifdef PIPE_BUFFER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [W-1:0] model_q[$];

  pipe_buffer #(.W(W), .RST('0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit model_in_ready();
`ifdef PIPE_BUFFER_SKID_EN
    return model_q.size() < DEPTH;
`else
    return (model_q.size() == 0) || out_ready;
`endif
  endfunction

  // Reference model: a bounded FIFO updated on each posedge from the inputs seen before it.
  always @(posedge clk) begin
    bit acc, cons;
    acc  = in_valid && model_in_ready();
    cons = (model_q.size() > 0) && out_ready;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (cons) void'(model_q.pop_front());
      if (acc) model_q.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, after inputs settle and before the next edge.
  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("mdl_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      check("mdl_count", {30'd0, count}, model_q.size());
      check("mdl_in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
      if (model_q.size() != 0) check("mdl_out_data", {16'd0, out_data}, {16'd0, model_q[0]});
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    $display("[TB] rst=%0b flush=%0b in_valid=%0b in_data=%04h out_ready=%0b", r, f, iv, d, ordy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b0;

    // Reset with traffic present
    drive(1, 0, 1, 16'hBEEF, 0);
    drive(1, 0, 1, 16'hBEEF, 0);
    drive(0, 0, 0, 16'h0000, 0);
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_count", {30'd0, count}, 0);
    check("rst_out_data", {16'd0, out_data}, 32'h0000);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    chk_en = 1;

    // Streaming: one transfer per cycle, one-cycle latency
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, W'(i), 1);
      #3;
      if (i > 1) begin
        check("stream_data", {16'd0, out_data}, i - 1);
        check("stream_count", {30'd0, count}, 1);
      end
    end
    drive(0, 0, 0, 16'h0000, 1);
    #3 check("stream_last", {16'd0, out_data}, 32'h0008);
    drive(0, 0, 0, 16'h0000, 1);
    #3 check("stream_drain", {30'd0, count}, 0);

`ifdef PIPE_BUFFER_SKID_EN
    // Stall: two entries absorbed, third held upstream
    drive(0, 0, 1, 16'h00A1, 0);
    drive(0, 0, 1, 16'h00A2, 0);
    drive(0, 0, 1, 16'h00A3, 0);
    #3;
    check("stall_count", {30'd0, count}, 2);
    check("stall_in_ready", {31'd0, in_ready}, 0);
    check("stall_data", {16'd0, out_data}, 32'h00A1);
    drive(0, 0, 1, 16'h00A3, 0);
    #3 check("stall_stable", {16'd0, out_data}, 32'h00A1);
    drive(0, 0, 1, 16'h00A3, 1);
    #3 check("stall_release", {16'd0, out_data}, 32'h00A1);
    drive(0, 0, 1, 16'h00A3, 1);
    #3;
    check("stall_second", {16'd0, out_data}, 32'h00A2);
    check("stall_ready_back", {31'd0, in_ready}, 1);
    drive(0, 0, 0, 16'h0000, 1);
    #3 check("stall_third", {16'd0, out_data}, 32'h00A3);
    drive(0, 0, 0, 16'h0000, 1);

    // Flush with two held entries and a simultaneous offer
    drive(0, 0, 1, 16'h00B1, 0);
    drive(0, 0, 1, 16'h00B2, 0);
    drive(0, 1, 1, 16'h00FF, 0);
    #3 check("flush_pre_count", {30'd0, count}, 2);
`else
    // Non-skid stall: in_ready follows out_ready combinationally
    drive(0, 0, 1, 16'h00A1, 0);
    drive(0, 0, 1, 16'h00A2, 0);
    #3;
    check("ns_in_ready_lo", {31'd0, in_ready}, 0);
    check("ns_count", {30'd0, count}, 1);
    check("ns_data", {16'd0, out_data}, 32'h00A1);
    out_ready = 1'b1;
    #1 check("ns_in_ready_hi", {31'd0, in_ready}, 1);
    drive(0, 0, 0, 16'h0000, 1);
    #3;
    check("ns_pass_through", {16'd0, out_data}, 32'h00A2);
    check("ns_count_after", {30'd0, count}, 1);
    drive(0, 0, 0, 16'h0000, 1);

    // Flush with one held entry while accept and consume would both fire
    drive(0, 0, 1, 16'h00B1, 0);
    drive(0, 1, 1, 16'h00FF, 1);
    #3 check("flush_pre_count", {30'd0, count}, 1);
`endif
    drive(0, 0, 0, 16'h0000, 1);
    #3;
    check("flush_count", {30'd0, count}, 0);
    check("flush_out_valid", {31'd0, out_valid}, 0);
    drive(0, 0, 0, 16'h0000, 1);
    #3 check("flush_no_ff", {31'd0, out_valid}, 0);

    // rst and flush together while holding data
    drive(0, 0, 1, 16'h00C1, 0);
    drive(1, 1, 0, 16'h0000, 0);
    #3 check("prio_pre_data", {16'd0, out_data}, 32'h00C1);
    drive(0, 0, 0, 16'h0000, 0);
    #3;
    check("prio_out_data", {16'd0, out_data}, 32'h0000);
    check("prio_count", {30'd0, count}, 0);
    check("prio_in_ready", {31'd0, in_ready}, 1);
    drive(0, 0, 0, 16'h0000, 0);
    drive(0, 0, 0, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
